// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, states,
// IR field positions, strobe bundle and opcode classification.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        HALT = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic pcout;
        logic pcin;
        logic marin;
        logic mdrin;
        logic mdrout;
        logic mdrread;
        logic irin;
        logic incpc;
        logic yin;
        logic yout;
        logic zin;
        logic zloout;
        logic zhiout;
        logic hiin;
        logic loin;
    } strobes_t;

    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     return CLS_BINARY;
            OP_MUL, OP_DIV:                      return CLS_MULDIV;
            OP_NEG, OP_NOT:                      return CLS_UNARY;
            OP_HALT:                             return CLS_HALT;
            default:                             return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-to-N one-hot register select decoder with enable; all zero when disabled.
module reg_sel_decode #(
    parameter int NUM_REGS = 16
) (
    input  logic                en,
    input  logic [3:0]          sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (sel == 4'(i));
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and execute (T3-T6) sequencing with
// memory-read handshake, timeout fault and halt.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                MDRread,
    output logic                IRin,
    output logic                IncPC,
    output logic                Yin,
    output logic                Yout,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIin,
    output logic                LOin,
    output logic [OPC_W-1:0]    ALU_opcode,
    output logic                halted,
    output logic                fault,
    output logic [3:0]          state_dbg
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;

    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    op_class_t        cls;

    strobes_t         s, so;
    logic             rin_en, rout_en;
    logic [3:0]       rin_sel, rout_sel;
    logic [OPC_W-1:0] alu_c;
    logic             unused_ir;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];
    assign cls       = classify(opcode);
    assign unused_ir = ^ir[RC_LSB-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T0;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        fault_d  = fault_q;
        s        = '0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_sel  = ra;
        rout_sel = '0;
        alu_c    = '0;

        case (state_q)
            T0: begin
                s.pcout = 1'b1;
                s.marin = 1'b1;
                s.incpc = 1'b1;
                s.zin   = 1'b1;
                state_d = T1;
            end
            T1: begin
                s.mdrread = 1'b1;
                s.mdrin   = 1'b1;
                // Incremented PC is taken from Z only on the accepted cycle,
                // so a long wait still updates PC exactly once.
                if (mem_ready) begin
                    s.zloout = 1'b1;
                    s.pcin   = 1'b1;
                    wait_d   = '0;
                    state_d  = T2;
                end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    wait_d  = '0;
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            T2: begin
                s.mdrout = 1'b1;
                s.irin   = 1'b1;
                state_d  = T3;
            end
            T3: begin
                case (cls)
                    CLS_HALT: state_d = HALT;
                    CLS_BINARY, CLS_UNARY: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        s.yin    = 1'b1;
                        state_d  = T4;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        s.yin    = 1'b1;
                        state_d  = T4;
                    end
                    default: begin
                        fault_d = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T4: begin
                s.zin   = 1'b1;
                alu_c   = OPC_W'(opcode);
                state_d = T5;
                case (cls)
                    CLS_BINARY: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                    end
                    default: s.yout = 1'b1;
                endcase
            end
            T5: begin
                s.zloout = 1'b1;
                if (cls == CLS_MULDIV) begin
                    s.loin  = 1'b1;
                    state_d = T6;
                end else begin
                    rin_en  = 1'b1;
                    state_d = T0;
                end
            end
            T6: begin
                s.zhiout = 1'b1;
                s.hiin   = 1'b1;
                state_d  = T0;
            end
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
    end

    // Reset blanks every output combinationally so an aborted instruction
    // cannot emit a write strobe on the cycle clr is sampled.
    assign so         = clr ? '0 : s;
    assign ALU_opcode = clr ? '0 : alu_c;
    assign halted     = !clr && (state_q == HALT);
    assign fault      = !clr && fault_q;
    assign state_dbg  = clr ? 4'd0 : state_q;

    assign PCout   = so.pcout;
    assign PCin    = so.pcin;
    assign MARin   = so.marin;
    assign MDRin   = so.mdrin;
    assign MDRout  = so.mdrout;
    assign MDRread = so.mdrread;
    assign IRin    = so.irin;
    assign IncPC   = so.incpc;
    assign Yin     = so.yin;
    assign Yout    = so.yout;
    assign Zin     = so.zin;
    assign ZLOout  = so.zloout;
    assign ZHIout  = so.zhiout;
    assign HIin    = so.hiin;
    assign LOin    = so.loin;

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .en     (rin_en && !clr),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .en     (rout_en && !clr),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule
